// File: rtl/div_mc_param.sv
// div_mc_param: multi-cycle restoring divider, signed or unsigned.
// One quotient bit per cycle, with sign fix-up on the final edge.
// Divide-by-zero (and, with DIV_EARLY_TERM_EN defined, any divisor whose
// magnitude exceeds the dividend's) takes the short BYPASS path.
// Macro: DIV_EARLY_TERM_EN enables early termination; undefined by default.
//
// Handshake: start_i is sampled only while the FSM is FREE and annul_i is
// low. The edge that samples it is the accepting edge, and the operands are
// captured on that same edge. ready_o is a one-cycle pulse; result_o and
// div_zero_o are valid during that pulse and hold until the next result is
// loaded. busy_o is high in every state other than FREE. annul_i drops an
// operation in ON or BYPASS without producing a pulse.
module div_mc_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYPASS = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;    // dividend magnitude, shifted out as quotient shifts in
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic             neg1;   // captured dividend sign
  logic             neg2;   // captured divisor sign
  logic             sdiv;   // captured signed_div_i
  logic             dzero;  // captured divisor == 0

  // Two's-complement negate at operand width (wraps for the most-negative value).
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             in_zero;
  logic             early_hit;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] byp_rem;

  // Operand magnitudes and the short-path decision for the accepting edge.
  always_comb begin
    mag1      = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
    mag2      = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
    in_zero   = (opdata2_i == '0);
`ifdef DIV_EARLY_TERM_EN
    early_hit = !in_zero && (mag2 > mag1);
`else
    early_hit = 1'b0;
`endif
  end

  // Restoring trial subtract and the end-of-run sign fix-up.
  always_comb begin
    // A borrow out of the top bit means the trial went negative.
    trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    q_fix   = (sdiv && (neg1 ^ neg2)) ? negate(quo) : quo;
    r_fix   = (sdiv && neg1) ? negate(rem) : rem;
    // quo still holds the dividend magnitude in BYPASS; rebuild the original dividend.
    byp_rem = (sdiv && neg1) ? negate(quo) : quo;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FREE;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      neg1       <= 1'b0;
      neg2       <= 1'b0;
      sdiv       <= 1'b0;
      dzero      <= 1'b0;
      result_o   <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            quo   <= mag1;
            rem   <= '0;
            dvs   <= mag2;
            neg1  <= signed_div_i && opdata1_i[WIDTH-1];
            neg2  <= signed_div_i && opdata2_i[WIDTH-1];
            sdiv  <= signed_div_i;
            dzero <= in_zero;
            cnt   <= '0;
            state <= (in_zero || early_hit) ? BYPASS : ON;
          end
        end
        BYPASS: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            // Divide by zero yields an all-ones quotient; early termination yields zero.
            result_o   <= {byp_rem, dzero ? {WIDTH{1'b1}} : {WIDTH{1'b0}}};
            div_zero_o <= dzero;
            state      <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            cnt   <= '0;
            state <= FREE;
          end else if (cnt == LAST_CNT) begin
            result_o   <= {r_fix, q_fix};
            div_zero_o <= 1'b0;
            cnt        <= '0;
            state      <= END;
          end else begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          // Single result cycle; start and annul are both ignored here.
          state <= FREE;
        end
        default: state <= FREE;
      endcase
    end
  end

  assign ready_o   = (state == END);
  assign busy_o    = (state != FREE);
  assign dbg_state = state;

endmodule

// File: tb/tb_div_mc_param.sv
// tb_div_mc_param: table vectors, random vectors and directed multi-cycle
// sequences for div_mc_param (WIDTH=32 main instance, WIDTH=8 second instance).
module tb_div_mc_param;

  localparam int W  = 32;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (WIDTH=32) ----------------
  logic           signed_div, start, annul;
  logic [W-1:0]   op1, op2;
  logic [2*W-1:0] result;
  logic           ready, busy, div_zero;
  logic [1:0]     dbg_state;

  div_mc_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready), .busy_o(busy),
    .div_zero_o(div_zero), .dbg_state(dbg_state)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic            b8_sdiv, b8_start, b8_annul;
  logic [W8-1:0]   b8_op1, b8_op2;
  logic [2*W8-1:0] b8_result;
  logic            b8_ready, b8_busy, b8_dz;
  logic [1:0]      b8_state;

  div_mc_param #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .signed_div_i(b8_sdiv),
    .opdata1_i(b8_op1), .opdata2_i(b8_op2), .start_i(b8_start), .annul_i(b8_annul),
    .result_o(b8_result), .ready_o(b8_ready), .busy_o(b8_busy),
    .div_zero_o(b8_dz), .dbg_state(b8_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];      // {div_zero, remainder, quotient}
  logic [2*W:0] last_exp = '0; // value result/div_zero must hold between results

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 1'b1, 1'b0);
      end else begin
        check("result", {div_zero, result}, exp_q.pop_front());
      end
    end
  end

  // Reference model built on the simulator's own arithmetic.
  function automatic logic [2*W:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r, min_v, m_one;
    min_v = {1'b1, {(W-1){1'b0}}};
    m_one = {W{1'b1}};
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (s) begin
      if (a == min_v && b == m_one) begin
        q = min_v; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  // Rising edges after the accepting edge until ready is seen.
  function automatic int exp_lat(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (b == '0) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (mb > ma) return 1;
`endif
    if (ma == mb) return W + 1; // keeps ma/mb referenced when early termination is off
    return W + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_div(input string tag, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W:0] e);
    int lat, want;
    want = exp_lat(s, a, b);
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not matter.
    start = 1'b0; op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 100);
    check({tag, "_lat"}, lat, want);
    if (!ready) exp_q.delete();
    @(posedge clk); #1;
    check({tag, "_pulse"}, {ready, busy}, 2'b00);
    last_exp = e;
  endtask

  task automatic run_div8(input string tag, input logic [W8-1:0] a, input logic [W8-1:0] b,
                          input logic [W8-1:0] q, input logic [W8-1:0] r);
    int lat;
    @(negedge clk);
    b8_sdiv = 1'b0; b8_op1 = a; b8_op2 = b; b8_start = 1'b1;
    @(posedge clk); #1;
    b8_start = 1'b0; b8_op1 = 8'($urandom); b8_op2 = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!b8_ready && lat < 100);
    check({tag, "_lat"}, lat, W8 + 1);
    check({tag, "_res"}, {b8_dz, b8_result}, {1'b0, r, q});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {b8_ready, b8_busy}, 2'b00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           dz;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ready, r1, r2;
    logic [W-1:0] ra, rb;
    bit rs;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd7,          32'hEDB6_DB6E,  32'hFFFF_FFFE,  1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[12] = '{1'b1, 32'd3,          32'hFFFF_FFF6,  32'd0,          32'd3,          1'b0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFD,  32'h0000_0010,  32'd0,          32'hFFFF_FFFD,  1'b0};

    // Reset state
    rst_n = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    b8_sdiv = 1'b0; b8_start = 1'b0; b8_annul = 1'b0; b8_op1 = '0; b8_op2 = '0;
    #1;
    check("reset_outputs", {result, ready, busy, div_zero, dbg_state}, '0);
    check("reset_outputs8", {b8_result, b8_ready, b8_busy, b8_dz}, '0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, ready}, 2'b00);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
              {vecs[i].dz, vecs[i].r, vecs[i].q});
    end

    // Random vectors against the model
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 40)) : W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 50));
      run_div($sformatf("rnd%0d", i), rs, ra, rb, model(rs, ra, rb));
    end

    // Start held high: ignored while busy and in END, re-accepted from FREE
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    exp_q.push_back({1'b0, 32'd2, 32'd14});
    exp_q.push_back(model(1'b0, 32'd200, 32'd3));
    @(posedge clk); #1;
    n_ready = 0; r1 = 0; r2 = 0;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin op1 = 32'd200; op2 = 32'd3; end
      if (n == 36) start = 1'b0;
      if (ready) begin
        n_ready++;
        if (n_ready == 1) r1 = n; else r2 = n;
      end
    end
    check("held_start_first", r1, W + 1);
    check("held_start_second", r2, 2 * W + 4);
    check("held_start_pulses", n_ready, 2);
    last_exp = model(1'b0, 32'd200, 32'd3);

    // Annul at iteration 10 of 100/7
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_on_busy", {busy, ready}, 2'b00);
    check("annul_on_hold", {div_zero, result}, last_exp);
    repeat (40) @(posedge clk);
    run_div("after_annul", 1'b0, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});

    // Annul in BYPASS (5/0)
    @(negedge clk);
    op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_byp_busy", {busy, ready}, 2'b00);
    check("annul_byp_hold", {div_zero, result}, last_exp);
    repeat (3) @(posedge clk);

    // Annul together with start in FREE suppresses acceptance
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    check("annul_start_free", busy, 1'b0);
    repeat (3) @(posedge clk);

    // WIDTH=8 normal divide
    run_div8("w8_200_3", 8'd200, 8'd3, 8'd66, 8'd2);

    // Asynchronous reset mid-divide on both instances
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    b8_op1 = 8'd200; b8_op2 = 8'd3; b8_start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; b8_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset32", {result, ready, busy, div_zero}, '0);
    check("async_reset8", {b8_result, b8_ready, b8_busy, b8_dz}, '0);
    last_exp = '0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_op_after_reset", {busy, b8_busy, result}, '0);

    // Both instances complete normally after reset
    run_div8("w8_after_reset", 8'd200, 8'd3, 8'd66, 8'd2);
    run_div("after_reset", 1'b0, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
